// File: rtl/key_expand.sv
// key_expand: iterative AES-128 key schedule producing one round key per clock.
// Round keys are streamed out and kept in an 11-entry store for out-of-order readback.

module key_rcon (
    input  logic [3:0] idx_i,
    output logic [7:0] rcon_o
);
    always_comb begin
        case (idx_i)
            4'd0:    rcon_o = 8'h01;
            4'd1:    rcon_o = 8'h02;
            4'd2:    rcon_o = 8'h04;
            4'd3:    rcon_o = 8'h08;
            4'd4:    rcon_o = 8'h10;
            4'd5:    rcon_o = 8'h20;
            4'd6:    rcon_o = 8'h40;
            4'd7:    rcon_o = 8'h80;
            4'd8:    rcon_o = 8'h1b;
            4'd9:    rcon_o = 8'h36;
            default: rcon_o = 8'h00;
        endcase
    end
endmodule

module key_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    logic [7:0] inv;

    assign inv = gf_inv(a_i);
    assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// state  | meaning
// IDLE   | waiting for start; last complete schedule readable if keys_ready
// EXPAND | computing round keys 1..10, one per clock
module key_expand (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic         busy_o,
    output logic         rk_valid_o,
    output logic [3:0]   rk_idx_o,
    output logic [127:0] rk_o,
    output logic         done_o,
    output logic         keys_ready_o,
    input  logic [3:0]   rd_idx_i,
    output logic [127:0] rd_key_o
);
    typedef enum logic {S_IDLE, S_EXPAND} state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic         rk_valid_q, rk_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         keys_ready_q, keys_ready_d;
    logic [127:0] slot_q [11];

    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] wr_data;

    logic [3:0]   rcon_idx;
    logic [7:0]   rcon;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;

    // Index held at 0 outside EXPAND so the ROM default is never selected.
    assign rcon_idx = (state_q == S_EXPAND) ? (round_q - 4'd1) : 4'd0;

    key_rcon u_rcon (
        .idx_i  (rcon_idx),
        .rcon_o (rcon)
    );

    assign {p0, p1, p2, p3} = rk_q;
    assign rot_w = {p3[23:0], p3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        key_sbox u_sbox (
            .a_i (rot_w[8*b +: 8]),
            .s_o (sub_w[8*b +: 8])
        );
    end

    assign t_w = sub_w ^ {rcon, 24'h000000};
    assign n0  = p0 ^ t_w;
    assign n1  = p1 ^ n0;
    assign n2  = p2 ^ n1;
    assign n3  = p3 ^ n2;

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        rk_d         = rk_q;
        rk_idx_d     = rk_idx_q;
        rk_valid_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        keys_ready_d = keys_ready_q;
        wr_en        = 1'b0;
        wr_idx       = 4'd0;
        wr_data      = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rk_d         = key_i;
                    rk_idx_d     = 4'd0;
                    rk_valid_d   = 1'b1;
                    busy_d       = 1'b1;
                    keys_ready_d = 1'b0;
                    round_d      = 4'd1;
                    state_d      = S_EXPAND;
                    wr_en        = 1'b1;
                    wr_idx       = 4'd0;
                    wr_data      = key_i;
                end
            end
            S_EXPAND: begin
                rk_d       = {n0, n1, n2, n3};
                rk_idx_d   = round_q;
                rk_valid_d = 1'b1;
                busy_d     = 1'b1;
                wr_en      = 1'b1;
                wr_idx     = round_q;
                wr_data    = {n0, n1, n2, n3};
                if (round_q == LAST_ROUND) begin
                    done_d       = 1'b1;
                    keys_ready_d = 1'b1;
                    round_d      = 4'd0;
                    state_d      = S_IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            round_q      <= 4'd0;
            rk_q         <= '0;
            rk_idx_q     <= 4'd0;
            rk_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_ready_q <= 1'b0;
            for (int i = 0; i < 11; i++) slot_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            rk_q         <= rk_d;
            rk_idx_q     <= rk_idx_d;
            rk_valid_q   <= rk_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_ready_q <= keys_ready_d;
            if (wr_en) slot_q[wr_idx] <= wr_data;
        end
    end

    assign busy_o       = busy_q;
    assign rk_valid_o   = rk_valid_q;
    assign rk_idx_o     = rk_idx_q;
    assign rk_o         = rk_q;
    assign done_o       = done_q;
    assign keys_ready_o = keys_ready_q;
    assign rd_key_o     = (keys_ready_q && (rd_idx_i <= LAST_ROUND)) ? slot_q[rd_idx_i] : '0;
endmodule

// File: tb/tb_key_expand.sv
// Bench for key_expand: FIPS-197 vectors, multi-cycle corner cases and random keys
// checked against a word-level FIPS key-expansion model.

module tb_key_expand;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [3:0]   rd_idx = 4'd0;
    logic         busy, rk_valid, done, keys_ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk, rd_key;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [5];
    logic [7:0]   sb [256];
    logic [7:0]   rc [10];
    logic [127:0] mexp [11];
    logic [127:0] cap [11];

    key_expand dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .key_i        (key),
        .busy_o       (busy),
        .rk_valid_o   (rk_valid),
        .rk_idx_o     (rk_idx),
        .rk_o         (rk),
        .done_o       (done),
        .keys_ready_o (keys_ready),
        .rd_idx_i     (rd_idx),
        .rd_key_o     (rd_key)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from exp/log tables over generator 3, then the bitwise affine map.
    task automatic build_tables();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] p, inv, c;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = p;
            lg[p] = i;
            p = p ^ xt(p);
        end
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
            for (int b = 0; b < 8; b++)
                sb[x][b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
        end
        rc[0] = 8'h01;
        for (int i = 1; i < 10; i++) rc[i] = xt(rc[i-1]);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc[i/4-1], 24'h000000};
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) mexp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic kick(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge where rk_idx=0 should be visible.
    task automatic stream(input string tag, input logic [127:0] k, input int ign_at,
                          input logic [127:0] ign_key, input bit chain, input logic [127:0] chain_key);
        logic [127:0] exp [11];
        int tbad;
        int mism;
        model(k);
        for (int r = 0; r < 11; r++) exp[r] = mexp[r];
        tbad = 0;
        for (int i = 0; i < 11; i++) begin
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || busy !== 1'b1 ||
                done !== (i == 10) || keys_ready !== (i == 10)) tbad++;
            if (i < 10 && rd_key !== '0) tbad++;
            cap[i] = rk;
            if (i == ign_at) begin
                start = 1'b1;
                key   = ign_key;
            end
            if (i == 10 && chain) begin
                start = 1'b1;
                key   = chain_key;
            end
            @(negedge clk);
            start = 1'b0;
        end
        if (!chain && (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || keys_ready !== 1'b1)) tbad++;
        check({tag, " timing"}, 128'(tbad), 128'd0);
        mism = 10;
        for (int i = 10; i >= 0; i--) if (cap[i] !== exp[i]) mism = i;
        check($sformatf("%s rk[%0d]", tag, mism), cap[mism], exp[mism]);
    endtask

    initial begin
        logic [127:0] k, nk, ik;
        int           ign;
        bit           ch;
        int           bad;

        vecs[0] = '{KEY_A1, 0,  KEY_A1};
        vecs[1] = '{KEY_A1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{KEY_A1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{'0,     1,  128'h62636363626363636263636362636363};
        vecs[4] = '{'0,     10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        build_tables();

        #1;
        check("reset flags", 128'({busy, rk_valid, rk_idx, done, keys_ready}), 128'd0);
        check("reset rk", rk, '0);
        check("reset rd_key", rd_key, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle flags", 128'({busy, rk_valid, done, keys_ready}), 128'd0);

        for (int v = 0; v < 5; v++) begin
            kick(vecs[v].key);
            stream($sformatf("vec%0d", v), vecs[v].key, -1, '0, 1'b0, '0);
            check($sformatf("vec%0d idx%0d", v, vecs[v].idx), cap[vecs[v].idx], vecs[v].exp);
        end

        // Zero-key schedule is in the store and in mexp: sweep every read address.
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            check($sformatf("rd_key[%0d]", i), rd_key, (i <= 10) ? mexp[i] : 128'd0);
        end
        rd_idx = 4'd0;

        @(negedge clk);
        kick(KEY_A1);
        stream("ignore", KEY_A1, 4, 128'hdeadbeef_01234567_89abcdef_55aa55aa, 1'b1, '0);
        stream("chain", '0, -1, '0, 1'b0, '0);

        kick(KEY_A1);
        repeat (6) @(negedge clk);
        check("pre-rst idx", 128'(rk_idx), 128'd6);
        rst = 1'b1;
        #1;
        check("async rst flags", 128'({busy, rk_valid, rk_idx, done, keys_ready}), 128'd0);
        check("async rst rk", rk, '0);
        check("async rst rd_key", rd_key, '0);
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0 || keys_ready !== 1'b0 || rk_valid !== 1'b0) bad++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || keys_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("no done after rst", 128'(bad), 128'd0);
        kick(KEY_A1);
        stream("after rst", KEY_A1, -1, '0, 1'b0, '0);
        check("after rst idx10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        k  = {$urandom, $urandom, $urandom, $urandom};
        ch = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (!ch) kick(k);
            ign = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            ik  = {$urandom, $urandom, $urandom, $urandom};
            nk  = {$urandom, $urandom, $urandom, $urandom};
            ch  = (n != 999) && ($urandom_range(0, 1) == 1);
            stream($sformatf("rand%0d", n), k, ign, ik, ch, nk);
            if (!ch) begin
                rd_idx = 4'($urandom_range(0, 15));
                #1;
                check($sformatf("rand%0d rd_key[%0d]", n, rd_idx), rd_key,
                      (rd_idx <= 4'd10) ? mexp[rd_idx] : 128'd0);
                rd_idx = 4'd0;
                @(negedge clk);
            end
            k = nk;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_expand.md
# key_expand

Iterative AES-128 key schedule that sits directly downstream of the round-constant ROM `rcon`. It takes a 128-bit cipher key, computes one round key per clock, and streams the 11 round keys to the cipher datapath. It also buffers all 11 keys in an internal register file so the decryption datapath can read them back in any order. Each round uses `rcon` (index = round − 1) and four byte S-box instances for SubWord.

## Interface
- No parameters; fixed to AES-128 (Nk=4, Nr=10).
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to expand `key`; sampled only when idle.
- key  input  128  cipher key; word w0 = key[127:96], w3 = key[31:0]; sampled on accepted start.
- busy  output  1  high from the cycle after accepted start through the cycle done is high.
- rk_valid  output  1  rk/rk_idx carry a new round key this cycle.
- rk_idx  output  4  round number 0..10 of rk.
- rk  output  128  round key, same word order as key.
- done  output  1  one-cycle pulse, coincident with rk_idx=10.
- keys_ready  output  1  register file holds a complete, consistent schedule.
- rd_idx  input  4  register-file read address 0..10.
- rd_key  output  128  combinational read of stored key rd_idx; 0 when rd_idx>10 or keys_ready=0.

## Operation
- States: IDLE, EXPAND.
- IDLE: start=1 → latch key into working register and slot 0, rk_idx=0, rk_valid=1, keys_ready←0, go EXPAND with round counter=1. start=0 → stay.
- EXPAND, round r (1..10), from previous key {p0,p1,p2,p3}:
  - t = SubWord(RotWord(p3)) ^ rcon(r−1); RotWord(w) = {w[23:0], w[31:24]}.
  - n0=p0^t, n1=p1^n0, n2=p2^n1, n3=p3^n2, all 32-bit XOR, no carries.
  - Register {n0..n3} into the working register and slot r; drive rk, rk_idx=r, rk_valid=1.
  - r=10: done=1, keys_ready←1, return to IDLE. Otherwise r increments.
- start while busy is ignored; the key input is not re-sampled.
- Start from IDLE with keys_ready=1: keys_ready drops the cycle after start, so stale and new keys never mix.
- rd_key is readable whenever keys_ready=1; reads during EXPAND return 0.
- rcon index is never outside 0..9 during EXPAND. The default-0 case of `rcon` must be unreachable.

## Timing
- Reset values: state=IDLE, busy=0, rk_valid=0, rk_idx=0, rk=0, done=0, keys_ready=0, round counter=0, register file cleared to 0.
- start accepted at edge T: rk_idx=0 valid after T; rk_idx=r valid after T+r; done and rk_idx=10 after T+10.
- Total: 11 consecutive rk_valid cycles with no gaps; busy high for those 11 cycles.
- The earliest next start is accepted at the edge where done is high, i.e. back-to-back. That start begins a new sequence, and rk_idx=0 of the new key follows rk_idx=10 directly.
- Reset asserted mid-EXPAND: all outputs go to reset values immediately (asynchronously). No done pulse. The partial schedule is discarded (keys_ready=0).
- rk_valid, done, and keys_ready are registered outputs. rd_key is combinational from the register file.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse → rk_idx0 = key, rk_idx1 = a0fafe1788542cb123a339392a6c7605, rk_idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done with idx10 exactly 10 cycles after idx0.
- All-zero key → rk_idx1 = 62636363626363636263636362636363, rk_idx10 = b4ef5bcb3e92e21123e951cf6f8f188e. Then sweep rd_idx 0..10 and check that each rd_key equals the streamed value; rd_idx=11..15 → 0.
- start re-asserted at rk_idx=4 with a different key → ignored; sequence completes with the original schedule. Then start with the zero key on the done cycle → the new zero-key sequence follows with no gap.
- rst pulsed at rk_idx=6 → all outputs 0 immediately, keys_ready=0, no done. A subsequent start with the A.1 key yields the correct full schedule.
- Random keys (≥1000) against a reference model: all 11 round keys match, busy/rk_valid high for exactly 11 cycles, keys_ready=0 throughout EXPAND.
